// File: rtl/rgb_pipe_buffer.sv
// Registered RGB output stage: optional 2x2 Bayer dithering down to OUT_BITS,
// forced black during blanking, and a DEPTH-stage pipeline with a global freeze.
module rgb_pipe_buffer #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*IN_BITS-1:0]  din,
  input  logic                         blank,
  input  logic                         line_start,
  input  logic                         frame_start,
  input  logic                         dither_en,
  input  logic                         freeze,
  output logic [CHANNELS*OUT_BITS-1:0] dout,
  output logic                         out_blank
);

  localparam int D = IN_BITS - OUT_BITS;

  logic                         y_r;
  logic                         x_r;
  logic                         y_s;
  logic                         x_s;
  logic [1:0]                   bayer_s;
  logic [CHANNELS*OUT_BITS-1:0] stage_in_s;
  logic [CHANNELS*OUT_BITS-1:0] data_r [DEPTH];
  logic                         blank_r [DEPTH];

  // Offset is scaled so the Bayer value lands just below the truncation point;
  // the sum is kept wide so saturation is detected instead of wrapping.
  function automatic logic [OUT_BITS-1:0] reduce_chan(
    input logic [IN_BITS-1:0] v,
    input logic [1:0]         b,
    input logic               en
  );
    logic [IN_BITS+1:0] off;
    logic [IN_BITS+1:0] sum;
    logic [IN_BITS-1:0] sat;
    logic [IN_BITS-1:0] shifted;
    off     = en ? (({{IN_BITS{1'b0}}, b} << D) >> 2) : {(IN_BITS+2){1'b0}};
    sum     = {2'b00, v} + off;
    sat     = (sum[IN_BITS+1:IN_BITS] != 2'b00) ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];
    shifted = sat >> D;
    return OUT_BITS'(shifted);
  endfunction

  // Phase for the current pixel and its Bayer threshold
  always_comb begin
    y_s = y_r;
    x_s = x_r;
    if (frame_start) begin
      y_s = 1'b0;
      x_s = 1'b0;
    end else if (line_start) begin
      y_s = ~y_r;
      x_s = 1'b0;
    end else begin
      y_s = y_r;
      x_s = x_r;
    end
    case ({y_s, x_s})
      2'b00:   bayer_s = 2'd0;
      2'b01:   bayer_s = 2'd2;
      2'b10:   bayer_s = 2'd3;
      2'b11:   bayer_s = 2'd1;
      default: bayer_s = 2'd0;
    endcase
  end

  // Per-channel reduction, black during blanking
  always_comb begin
    stage_in_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      stage_in_s[k*OUT_BITS +: OUT_BITS] = blank ? {OUT_BITS{1'b0}}
        : reduce_chan(din[k*IN_BITS +: IN_BITS], bayer_s, dither_en);
    end
  end

  // Phase registers; blank pixels do not advance x
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_r <= 1'b0;
      x_r <= 1'b0;
    end else if (!freeze) begin
      y_r <= y_s;
      x_r <= blank ? x_s : ~x_s;
    end
  end

  // Delay pipeline for data and blank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k]  <= '0;
        blank_r[k] <= 1'b1;
      end
    end else if (!freeze) begin
      data_r[0]  <= stage_in_s;
      blank_r[0] <= blank;
      for (int k = 1; k < DEPTH; k++) begin
        data_r[k]  <= data_r[k-1];
        blank_r[k] <= blank_r[k-1];
      end
    end
  end

  assign dout      = data_r[DEPTH-1];
  assign out_blank = blank_r[DEPTH-1];

endmodule
